// File: rtl/sevenseg_pkg.sv
// Shared glyph table and nibble-to-segment encoding for the seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Values 10..15 only render as letters when hex_mode is set.
  function automatic logic [6:0] encode(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] g;
    g = SEG_BLANK;
    case (nibble)
      4'd0:  g = SEG_0;
      4'd1:  g = SEG_1;
      4'd2:  g = SEG_2;
      4'd3:  g = SEG_3;
      4'd4:  g = SEG_4;
      4'd5:  g = SEG_5;
      4'd6:  g = SEG_6;
      4'd7:  g = SEG_7;
      4'd8:  g = SEG_8;
      4'd9:  g = SEG_9;
      4'd10: g = hex_mode ? SEG_A : SEG_BLANK;
      4'd11: g = hex_mode ? SEG_B : SEG_BLANK;
      4'd12: g = hex_mode ? SEG_C : SEG_BLANK;
      4'd13: g = hex_mode ? SEG_D : SEG_BLANK;
      4'd14: g = hex_mode ? SEG_E : SEG_BLANK;
      4'd15: g = hex_mode ? SEG_F : SEG_BLANK;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sevenseg_encoder.sv
// Combinational glyph encoder for the currently scanned digit, with a forced-blank override.
module sevenseg_encoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : encode(nibble, hex_mode);
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed N-digit seven-segment driver: prescaled scan, frame-synchronous latching,
// leading-zero blanking, blink and PWM brightness, all outputs registered.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 25000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic                    hex_mode,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          blink_phase;
  logic          wrap_q;
  logic          slot_end;
  logic          frame_wrap;

  logic [4*NUM_DIGITS-1:0] pd_digits, sh_digits;
  logic [NUM_DIGITS-1:0]   pd_dp, sh_dp;
  logic [NUM_DIGITS-1:0]   pd_blink, sh_blink;
  logic                    pd_blz, sh_blz;
  logic                    pd_hex, sh_hex;
  logic [2:0]              pd_bright, sh_bright;

  assign slot_end   = (pcnt == PW'(SCAN_DIV - 1));
  assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

  // load is a strobe with no back-pressure: it is accepted on any cycle rst is low, and
  // a load on the frame-wrap cycle bypasses pending straight into shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      idx         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      wrap_q      <= 1'b0;
      pd_digits   <= '0;
      pd_dp       <= '0;
      pd_blink    <= '0;
      pd_blz      <= 1'b0;
      pd_hex      <= 1'b0;
      pd_bright   <= '0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blink    <= '0;
      sh_blz      <= 1'b0;
      sh_hex      <= 1'b0;
      sh_bright   <= '0;
    end else begin
      pcnt   <= slot_end ? '0 : pcnt + 1'b1;
      wrap_q <= frame_wrap;
      if (slot_end) begin
        idx <= frame_wrap ? '0 : idx + 1'b1;
      end
      if (frame_wrap) begin
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt        <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      if (load) begin
        pd_digits <= digits_in;
        pd_dp     <= dp_in;
        pd_blink  <= blink_mask;
        pd_blz    <= blank_lz;
        pd_hex    <= hex_mode;
        pd_bright <= brightness;
      end
      if (frame_wrap) begin
        sh_digits <= load ? digits_in  : pd_digits;
        sh_dp     <= load ? dp_in      : pd_dp;
        sh_blink  <= load ? blink_mask : pd_blink;
        sh_blz    <= load ? blank_lz   : pd_blz;
        sh_hex    <= load ? hex_mode   : pd_hex;
        sh_bright <= load ? brightness : pd_bright;
      end
    end
  end

  // lz_vec[k] is set when digit k and every digit above it hold zero; digit 0 is never blanked.
  logic [NUM_DIGITS-1:0] lz_vec;
  logic                  zero_run;

  always_comb begin
    lz_vec   = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run  = zero_run && (sh_digits[4*k +: 4] == 4'd0);
      lz_vec[k] = zero_run;
    end
  end

  logic [3:0]            cur_nibble;
  logic                  lz_blank;
  logic                  blink_off;
  logic [31:0]           thr;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  always_comb begin
    cur_nibble = sh_digits[32'(idx) * 4 +: 4];
    lz_blank   = sh_blz && lz_vec[idx];
    blink_off  = blink_phase && sh_blink[idx];
    thr        = ((32'(sh_bright) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    pwm_on     = (32'(pcnt) < thr);
    an_next    = pwm_on ? ~(NUM_DIGITS'(1) << idx) : '1;
    dp_next    = ~(sh_dp[idx] && !blink_off);
  end

  sevenseg_encoder u_encoder (
    .nibble   (cur_nibble),
    .hex_mode (sh_hex),
    .blank    (lz_blank || blink_off),
    .seg      (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
      frame_tick <= wrap_q;
    end
  end

endmodule
